dmem_pipe: RTL and testbench

- Parametrised successor to the team's single-port data memory.
- Synchronous memory with a request/ready handshake, byte-lane write mask, configurable read latency (1 or 2 cycles) and optional hardware zero-fill after reset.
- Sits between the core's load/store unit and the data store; accepts one request per cycle when ready.

---
 rtl/dmem_pipe.sv | 146 ++++++++++++++
 tb/tb_dmem_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_pipe.sv
// dmem_pipe: single-port data memory with request/ready handshake, byte-lane
// write mask, 1- or 2-cycle read latency and optional zero-fill after reset.
//
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   Req_i       - request strobe, accepted when Ready_o is high
//   WEn_i       - 1 = write, 0 = read
//   Addr_i      - word address
//   ByteEn_i    - per-byte write enable (ignored for reads)
//   data_i      - write data
//   Ready_o     - block accepts a request this cycle
//   Busy_o      - zero-fill in progress
//   Valid_o     - one-cycle pulse: data_o carries a read result
//   data_o      - read data, held between pulses
module dmem_pipe #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Req_i,
  input  logic                  WEn_i,
  input  logic [ADDR_W-1:0]     Addr_i,
  input  logic [DATA_W/8-1:0]   ByteEn_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  Ready_o,
  output logic                  Busy_o,
  output logic                  Valid_o,
  output logic [DATA_W-1:0]     data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic        CLEAR_EN = (CLEAR_ON_RST != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   clr_cnt;
  logic               ready_q;
  logic               busy_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept_c;
  logic               rd_accept_c;
  logic               wr_accept_c;

  // ready_q is the registered view of "in IDLE", so an accept needs no decode
  assign accept_c    = Req_i & ready_q;
  assign rd_accept_c = accept_c & ~WEn_i;
  assign wr_accept_c = accept_c &  WEn_i;

  // Control FSM: reset lands in CLEAR (or IDLE when fill is disabled)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_EN ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
      ready_q <= 1'b0;
      busy_q  <= CLEAR_EN;
    end else begin
      case (state)
        ST_CLEAR: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          clr_cnt <= clr_cnt + CNT_W'(1);
          // Last word written on this edge; become ready on the same edge
          if (clr_cnt == CNT_W'(DEPTH - 1)) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: fill writes zeros, otherwise masked lane writes
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt[ADDR_W-1:0]] <= '0;
    end else if (wr_accept_c) begin
      for (int k = 0; k < LANES; k++) begin
        if (ByteEn_i[k]) begin
          mem[Addr_i][8*k +: 8] <= data_i[8*k +: 8];
        end
      end
    end
  end

  // First read stage: array sampled at the accept edge
  logic               s1_valid;
  logic [DATA_W-1:0]  s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_accept_c;
      if (rd_accept_c) begin
        s1_data <= mem[Addr_i];
      end
    end
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign Valid_o = s1_valid;
      assign data_o  = s1_data;
    end else begin : g_lat2
      logic               s2_valid;
      logic [DATA_W-1:0]  s2_data;

      // Extra output stage; data only moves on a valid beat so it holds
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign Valid_o = s2_valid;
      assign data_o  = s2_data;
    end
  endgenerate

  assign Ready_o = ready_q;
  assign Busy_o  = busy_q;

endmodule

// File: tb/tb_dmem_pipe.sv
// Bench for dmem_pipe: three instances (latency 1 with fill, latency 2 with
// fill, latency 1 without fill) checked against a behavioural memory model.
module tb_dmem_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_n_c;
  logic        Req;
  logic        WEn;
  logic [4:0]  Addr;
  logic [1:0]  ByteEn;
  logic [15:0] data_in;

  logic        ready_a, busy_a, valid_a;
  logic [15:0] data_a;
  logic        ready_b, busy_b, valid_b;
  logic [15:0] data_b;
  logic        ready_c, busy_c, valid_c;
  logic [15:0] data_c;

  always #5 clk = ~clk;

  dmem_pipe #(.ADDR_W(5), .DATA_W(16), .READ_LAT(1), .CLEAR_ON_RST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .Req_i(Req), .WEn_i(WEn), .Addr_i(Addr),
    .ByteEn_i(ByteEn), .data_i(data_in), .Ready_o(ready_a), .Busy_o(busy_a),
    .Valid_o(valid_a), .data_o(data_a));

  dmem_pipe #(.ADDR_W(5), .DATA_W(16), .READ_LAT(2), .CLEAR_ON_RST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .Req_i(Req), .WEn_i(WEn), .Addr_i(Addr),
    .ByteEn_i(ByteEn), .data_i(data_in), .Ready_o(ready_b), .Busy_o(busy_b),
    .Valid_o(valid_b), .data_o(data_b));

  dmem_pipe #(.ADDR_W(5), .DATA_W(16), .READ_LAT(1), .CLEAR_ON_RST(0)) u_c (
    .clk(clk), .rst_n(rst_n_c), .Req_i(Req), .WEn_i(WEn), .Addr_i(Addr),
    .ByteEn_i(ByteEn), .data_i(data_in), .Ready_o(ready_c), .Busy_o(busy_c),
    .Valid_o(valid_c), .data_o(data_c));

  // Reference model for instances a and b
  typedef struct {
    int          due;
    logic [15:0] d;
  } rd_t;

  logic [15:0] m_mem [32];
  int          fill_left;
  rd_t         qa[$];
  rd_t         qb[$];
  logic [15:0] last_a, last_b;
  logic        exp_va, exp_vb;
  int          cyc;
  logic [37:0] exp_vec, obs_vec;

  int checks = 0;
  int errors = 0;

  // One clock: drive at negedge, model the edge, sample at the next negedge
  task automatic step(input logic req, input logic wen, input logic [4:0] addr,
                      input logic [1:0] be, input logic [15:0] d);
    rd_t e;
    Req = req; WEn = wen; Addr = addr; ByteEn = be; data_in = d;
    @(posedge clk);
    cyc++;
    if (fill_left != 0) begin
      fill_left--;
    end else if (req) begin
      if (wen) begin
        for (int k = 0; k < 2; k++)
          if (be[k]) m_mem[addr][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.due = cyc;     e.d = m_mem[addr]; qa.push_back(e);
        e.due = cyc + 1; qb.push_back(e);
      end
    end
    @(negedge clk);
    exp_va = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      exp_va = 1'b1; last_a = qa[0].d; void'(qa.pop_front());
    end
    exp_vb = 1'b0;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      exp_vb = 1'b1; last_b = qb[0].d; void'(qb.pop_front());
    end
    exp_vec = {fill_left == 0, fill_left != 0, exp_va, last_a,
               fill_left == 0, fill_left != 0, exp_vb, last_b};
    obs_vec = {ready_a, busy_a, valid_a, data_a, ready_b, busy_b, valid_b, data_b};
    Req = 1'b0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    Req   = 1'b0;
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
    fill_left = 32;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int busy_n;
    @(negedge clk);
    rst_n_c = 1'b0;
    assert_reset();
    checks++;
    if ({ready_a, busy_a, valid_a, data_a, ready_b, busy_b, valid_b, data_b} !==
        {1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_values: got %b%b%b %h / %b%b%b %h, expected 010 0000 / 010 0000",
               ready_a, busy_a, valid_a, data_a, ready_b, busy_b, valid_b, data_b);
    end
    release_reset();
    busy_n = busy_a ? 1 : 0;
    for (int i = 0; i < 64 && !ready_a; i++) begin
      step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL fill_step %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      if (busy_a) busy_n++;
    end
    checks++;
    if (busy_n != 32 || ready_a !== 1'b1) begin
      errors++;
      $display("FAIL fill_length: busy cycles %0d ready %b, expected 32 and 1", busy_n, ready_a);
    end
    for (int i = 0; i < 33; i++) begin
      if (i < 32) step(1'b1, 1'b0, 5'(i), 2'b00, 16'h0);
      else        step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
      checks++;
      if (obs_vec !== exp_vec || (i < 32 && (valid_a !== 1'b1 || data_a !== 16'h0000))) begin
        errors++;
        $display("FAIL zero_read %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_dropped();
    assert_reset();
    release_reset();
    for (int i = 0; i < 64 && !ready_a; i++) begin
      if (i < 3) step(1'b1, 1'b1, 5'd3, 2'b11, 16'hFFFF);
      else       step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL drop_step %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    step(1'b1, 1'b0, 5'd3, 2'b00, 16'h0);
    checks++;
    if (obs_vec !== exp_vec || valid_a !== 1'b1 || data_a !== 16'h0000) begin
      errors++;
      $display("FAIL dropped_write: got v=%b d=%h expected v=1 d=0000", valid_a, data_a);
    end
    step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
  endtask

  task automatic test_write_read();
    step(1'b1, 1'b1, 5'd7, 2'b11, 16'hA5C3);
    step(1'b1, 1'b0, 5'd7, 2'b00, 16'h0);
    checks++;
    if (obs_vec !== exp_vec || valid_a !== 1'b1 || data_a !== 16'hA5C3 || valid_b !== 1'b0) begin
      errors++;
      $display("FAIL lat1_read: got va=%b da=%h vb=%b expected va=1 da=a5c3 vb=0",
               valid_a, data_a, valid_b);
    end
    step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
    checks++;
    if (obs_vec !== exp_vec || valid_a !== 1'b0 || data_a !== 16'hA5C3 ||
        valid_b !== 1'b1 || data_b !== 16'hA5C3) begin
      errors++;
      $display("FAIL lat2_read: got va=%b da=%h vb=%b db=%h expected 0 a5c3 1 a5c3",
               valid_a, data_a, valid_b, data_b);
    end
    step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
    checks++;
    if (obs_vec !== exp_vec || valid_b !== 1'b0 || data_b !== 16'hA5C3) begin
      errors++;
      $display("FAIL lat2_hold: got vb=%b db=%h expected vb=0 db=a5c3", valid_b, data_b);
    end
  endtask

  task automatic test_byte_mask();
    step(1'b1, 1'b1, 5'd7, 2'b01, 16'h1234);
    step(1'b1, 1'b0, 5'd7, 2'b00, 16'h0);
    checks++;
    if (obs_vec !== exp_vec || data_a !== 16'hA534) begin
      errors++;
      $display("FAIL mask_low: got %h expected a534", data_a);
    end
    step(1'b1, 1'b1, 5'd7, 2'b00, 16'hFFFF);
    step(1'b1, 1'b0, 5'd7, 2'b00, 16'h0);
    checks++;
    if (obs_vec !== exp_vec || valid_a !== 1'b1 || data_a !== 16'hA534) begin
      errors++;
      $display("FAIL mask_none: got v=%b d=%h expected v=1 d=a534", valid_a, data_a);
    end
    step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, 5'(i), 2'b11, 16'(i) * 16'h0101);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b_write %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    for (int i = 31; i >= 0; i--) begin
      step(1'b1, 1'b0, 5'(i), 2'b00, 16'h0);
      if (valid_a) pulses++;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b_read %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      if (i == 31) begin
        checks++;
        if (data_a !== 16'h1F1F) begin
          errors++;
          $display("FAIL b2b_first: got %h expected 1f1f", data_a);
        end
      end
    end
    step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
    checks++;
    if (obs_vec !== exp_vec || pulses != 32 || data_b !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d pulses db=%h expected 32 and 0000", pulses, data_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
           2'($urandom), 16'($urandom));
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_drain %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_mid_reset();
    int busy_n;
    step(1'b1, 1'b1, 5'd9, 2'b11, 16'hBEEF);
    step(1'b1, 1'b0, 5'd9, 2'b00, 16'h0);
    step(1'b1, 1'b0, 5'd9, 2'b00, 16'h0);
    checks++;
    if (obs_vec !== exp_vec || valid_a !== 1'b1 || data_a !== 16'hBEEF) begin
      errors++;
      $display("FAIL pre_reset_read: got v=%b d=%h expected v=1 d=beef", valid_a, data_a);
    end
    assert_reset();
    checks++;
    if ({valid_a, data_a, valid_b, data_b, ready_a, busy_a} !== {1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_flush: got va=%b da=%h vb=%b db=%h rdy=%b busy=%b expected all 0, busy 1",
               valid_a, data_a, valid_b, data_b, ready_a, busy_a);
    end
    release_reset();
    busy_n = busy_a ? 1 : 0;
    for (int i = 0; i < 64 && !ready_a; i++) begin
      if (i == 0) step(1'b1, 1'b0, 5'd9, 2'b00, 16'h0);
      else        step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
      if (busy_a) busy_n++;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL mid_fill %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (busy_n != 32 || ready_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill_length: busy cycles %0d ready %b, expected 32 and 1", busy_n, ready_a);
    end
    step(1'b1, 1'b0, 5'd9, 2'b00, 16'h0);
    checks++;
    if (obs_vec !== exp_vec || data_a !== 16'h0000) begin
      errors++;
      $display("FAIL mid_refill_data: got %h expected 0000", data_a);
    end
    step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
  endtask

  task automatic test_noclear();
    checks++;
    if ({ready_c, busy_c, valid_c, data_c} !== {1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL noclear_reset: got r=%b b=%b v=%b d=%h expected 0 0 0 0000",
               ready_c, busy_c, valid_c, data_c);
    end
    rst_n_c = 1'b1;
    step(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
    checks++;
    if (ready_c !== 1'b1 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL noclear_ready: got r=%b b=%b expected r=1 b=0", ready_c, busy_c);
    end
    step(1'b1, 1'b1, 5'd12, 2'b11, 16'h5A3C);
    step(1'b1, 1'b0, 5'd12, 2'b00, 16'h0);
    checks++;
    if (valid_c !== 1'b1 || data_c !== 16'h5A3C || obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL noclear_read: got v=%b d=%h expected v=1 d=5a3c", valid_c, data_c);
    end
  endtask

  initial begin
    rst_n = 1'b1; rst_n_c = 1'b1;
    Req = 1'b0; WEn = 1'b0; Addr = '0; ByteEn = '0; data_in = '0;
    cyc = 0; fill_left = 32; last_a = '0; last_b = '0;
    test_reset();
    test_dropped();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_noclear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
